// File: rtl/fetch_if.sv
// Bus bundle between the fetch unit, its instruction memory and the downstream instruction FIFO.
// The master side is the fetch unit; the slave side is memory, FIFO and pipeline control.
interface fetch_if #(
    parameter int XLEN = 32
);
    logic              fetch_en;
    logic              redirect_en;
    logic [XLEN-1:0]   redirect_pc;
    logic              mem_rd_en;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_rd_data;
    logic              fifo_wr_en;
    logic [2*XLEN-1:0] fifo_data_in;
    logic              fifo_full;

    modport master (
        input  fetch_en, redirect_en, redirect_pc, mem_rd_data, fifo_full,
        output mem_rd_en, mem_addr, fifo_wr_en, fifo_data_in
    );

    modport slave (
        output fetch_en, redirect_en, redirect_pc, mem_rd_data, fifo_full,
        input  mem_rd_en, mem_addr, fifo_wr_en, fifo_data_in
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: streams sequential reads from a 1-cycle-latency memory into a FIFO,
// with a one-entry hold buffer absorbing a response that meets a full FIFO.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
    logic              pend_q, pend_d;
    logic              hold_valid_q, hold_valid_d;
    logic [2*XLEN-1:0] hold_data_q, hold_data_d;
    logic              issue;
    logic [2*XLEN-1:0] resp_word;

    assign bus.mem_addr = pc_q;
    assign resp_word    = {pend_pc_q, bus.mem_rd_data};
    assign issue        = (state_q == RUN) && bus.fetch_en && !bus.fifo_full
                          && !hold_valid_q && !bus.redirect_en;

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        pend_pc_d        = pend_pc_q;
        pend_d           = 1'b0;
        hold_valid_d     = hold_valid_q;
        hold_data_d      = hold_data_q;
        bus.mem_rd_en    = 1'b0;
        bus.fifo_wr_en   = 1'b0;
        bus.fifo_data_in = '0;

        if (bus.redirect_en) begin
            // Redirect flushes everything in flight, including a response arriving now.
            pc_d         = bus.redirect_pc;
            hold_valid_d = 1'b0;
            hold_data_d  = '0;
            state_d      = bus.fetch_en ? RUN : IDLE;
        end else begin
            if (issue) begin
                bus.mem_rd_en = 1'b1;
                pend_pc_d     = pc_q;
                pend_d        = 1'b1;
                pc_d          = pc_q + XLEN'(4);
            end

            // A response and a held word never coexist: capture only happens when full,
            // and no request is issued until the hold buffer drains.
            if (pend_q) begin
                if (!bus.fifo_full) begin
                    bus.fifo_wr_en   = 1'b1;
                    bus.fifo_data_in = resp_word;
                end else begin
                    hold_valid_d = 1'b1;
                    hold_data_d  = resp_word;
                end
            end else if (hold_valid_q && !bus.fifo_full) begin
                bus.fifo_wr_en   = 1'b1;
                bus.fifo_data_in = hold_data_q;
                hold_valid_d     = 1'b0;
            end

            case (state_q)
                IDLE: if (bus.fetch_en) state_d = RUN;
                RUN: begin
                    if (pend_q && bus.fifo_full)
                        state_d = HOLD;
                    else if (!bus.fetch_en && !pend_q && !hold_valid_q)
                        state_d = IDLE;
                end
                HOLD: if (!bus.fifo_full) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            pend_q       <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_q       <= pend_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirect, wrap and reset scenarios,
// plus a monitor on FIFO writes (never while full, pcs sequential between flushes).
module tb_fetch_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic        sb_valid;
    logic [31:0] sb_last;

    fetch_if #(.XLEN(32)) bus ();
    fetch_if #(.XLEN(32)) wbus ();

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (wbus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory models: data is addr+0x100 one cycle after a request, junk otherwise.
    always @(posedge clk) begin
        bus.mem_rd_data  <= bus.mem_rd_en  ? bus.mem_addr  + 32'h100 : 32'hDEAD_BEEF;
        wbus.mem_rd_data <= wbus.mem_rd_en ? wbus.mem_addr + 32'h100 : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        #2;
        if (rst || bus.redirect_en) begin
            sb_valid = 1'b0;
        end else if (bus.fifo_wr_en) begin
            n_checks++;
            if (bus.fifo_full !== 1'b0) begin
                n_fail++;
                $display("FAIL sb_full: fifo_wr_en=1 with fifo_full=%b required 0", bus.fifo_full);
            end
            if (sb_valid) begin
                n_checks++;
                if (bus.fifo_data_in[63:32] !== sb_last + 32'h4) begin
                    n_fail++;
                    $display("FAIL sb_seq: written pc=%h required %h", bus.fifo_data_in[63:32], sb_last + 32'h4);
                end
            end
            sb_last  = bus.fifo_data_in[63:32];
            sb_valid = 1'b1;
        end
    end

    task automatic cyc(input logic r, input logic fe, input logic rd, input logic [31:0] rpc, input logic ff);
        @(negedge clk);
        rst             = r;
        bus.fetch_en    = fe;
        bus.redirect_en = rd;
        bus.redirect_pc = rpc;
        bus.fifo_full   = ff;
        #1;
    endtask

    task automatic test_reset;
        cyc(1, 0, 0, 0, 0);
        n_checks++; if (bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b required 0", bus.mem_rd_en); end
        n_checks++; if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b required 0", bus.fifo_wr_en); end
        n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h required 0", bus.mem_addr); end
        n_checks++; if (bus.fifo_data_in !== 64'h0) begin n_fail++; $display("FAIL rst_data: got %h required 0", bus.fifo_data_in); end
        cyc(1, 1, 0, 0, 0);
        n_checks++; if (bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en_fe: got %b required 0", bus.mem_rd_en); end
        n_checks++; if (wbus.mem_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL rst_addr_wrap: got %h required fffffff8", wbus.mem_addr); end
    endtask

    task automatic test_stream;
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        n_checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL stream_req0: rd_en=%b addr=%h required 1/0", bus.mem_rd_en, bus.mem_addr); end
        n_checks++; if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL stream_nowr: got %b required 0", bus.fifo_wr_en); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0);
            n_checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'(4 * (i + 1))) begin n_fail++; $display("FAIL stream_req%0d: rd_en=%b addr=%h required 1/%h", i + 1, bus.mem_rd_en, bus.mem_addr, 32'(4 * (i + 1))); end
            n_checks++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_data_in !== {32'(4 * i), 32'(4 * i + 256)}) begin n_fail++; $display("FAIL stream_wr%0d: wr_en=%b data=%h required 1/%h", i, bus.fifo_wr_en, bus.fifo_data_in, {32'(4 * i), 32'(4 * i + 256)}); end
        end
    endtask

    task automatic test_backpressure;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        n_checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h8) begin n_fail++; $display("FAIL bp_req8: rd_en=%b addr=%h required 1/8", bus.mem_rd_en, bus.mem_addr); end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 1);
            n_checks++; if (bus.mem_rd_en !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL bp_full%0d: rd_en=%b wr_en=%b required 0/0", i, bus.mem_rd_en, bus.fifo_wr_en); end
        end
        cyc(0, 1, 0, 0, 0);
        n_checks++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_data_in !== {32'h8, 32'h108}) begin n_fail++; $display("FAIL bp_drain: wr_en=%b data=%h required 1/00000008_00000108", bus.fifo_wr_en, bus.fifo_data_in); end
        n_checks++; if (bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_drain_noreq: got %b required 0", bus.mem_rd_en); end
        cyc(0, 1, 0, 0, 0);
        n_checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'hC || bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL bp_reqC: rd_en=%b addr=%h wr_en=%b required 1/c/0", bus.mem_rd_en, bus.mem_addr, bus.fifo_wr_en); end
    endtask

    // Continues from test_backpressure: the response for 0xC is in flight.
    task automatic test_redirect;
        cyc(0, 1, 1, 32'h40, 0);
        n_checks++; if (bus.mem_rd_en !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rd_flush: rd_en=%b wr_en=%b required 0/0", bus.mem_rd_en, bus.fifo_wr_en); end
        cyc(0, 1, 0, 0, 0);
        n_checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h40 || bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rd_req40: rd_en=%b addr=%h wr_en=%b required 1/40/0", bus.mem_rd_en, bus.mem_addr, bus.fifo_wr_en); end
        cyc(0, 1, 0, 0, 0);
        n_checks++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_data_in !== {32'h40, 32'h140}) begin n_fail++; $display("FAIL rd_wr40: wr_en=%b data=%h required 1/00000040_00000140", bus.fifo_wr_en, bus.fifo_data_in); end
        cyc(0, 0, 0, 0, 0);
        n_checks++; if (bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL stop_noreq: got %b required 0", bus.mem_rd_en); end
        n_checks++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_data_in !== {32'h44, 32'h144}) begin n_fail++; $display("FAIL stop_wr44: wr_en=%b data=%h required 1/00000044_00000144", bus.fifo_wr_en, bus.fifo_data_in); end
        cyc(0, 0, 0, 0, 0);
        n_checks++; if (bus.mem_rd_en !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL stop_quiet: rd_en=%b wr_en=%b required 0/0", bus.mem_rd_en, bus.fifo_wr_en); end
        cyc(0, 1, 0, 0, 0);
        n_checks++; if (bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL idle_noreq: got %b required 0", bus.mem_rd_en); end
        cyc(0, 1, 0, 0, 0);
        n_checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h48) begin n_fail++; $display("FAIL restart_req48: rd_en=%b addr=%h required 1/48", bus.mem_rd_en, bus.mem_addr); end
    endtask

    task automatic test_redirect_hold;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 1, 32'h80, 0);
        n_checks++; if (bus.fifo_wr_en !== 1'b0 || bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rdh_flush: wr_en=%b rd_en=%b required 0/0", bus.fifo_wr_en, bus.mem_rd_en); end
        cyc(0, 1, 0, 0, 0);
        n_checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h80 || bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rdh_req80: rd_en=%b addr=%h wr_en=%b required 1/80/0", bus.mem_rd_en, bus.mem_addr, bus.fifo_wr_en); end
        cyc(0, 1, 0, 0, 0);
        n_checks++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_data_in !== {32'h80, 32'h180}) begin n_fail++; $display("FAIL rdh_wr80: wr_en=%b data=%h required 1/00000080_00000180", bus.fifo_wr_en, bus.fifo_data_in); end
    endtask

    task automatic test_reset_hold;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        n_checks++; if (bus.mem_addr !== 32'h4 || bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rh_held: addr=%h wr_en=%b required 4/0", bus.mem_addr, bus.fifo_wr_en); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.mem_addr !== 32'h0 || bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rh_async: addr=%h wr_en=%b required 0/0", bus.mem_addr, bus.fifo_wr_en); end
        cyc(0, 1, 0, 0, 0);
        n_checks++; if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rh_rel0: wr_en=%b required 0", bus.fifo_wr_en); end
        cyc(0, 1, 0, 0, 0);
        n_checks++; if (bus.fifo_wr_en !== 1'b0 || bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rh_rel1: wr_en=%b rd_en=%b addr=%h required 0/1/0", bus.fifo_wr_en, bus.mem_rd_en, bus.mem_addr); end
    endtask

    task automatic test_wrap;
        wbus.fetch_en = 1'b1;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        n_checks++; if (wbus.mem_rd_en !== 1'b1 || wbus.mem_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_req0: rd_en=%b addr=%h required 1/fffffff8", wbus.mem_rd_en, wbus.mem_addr); end
        cyc(0, 0, 0, 0, 0);
        n_checks++; if (wbus.mem_addr !== 32'hFFFF_FFFC || wbus.fifo_data_in !== {32'hFFFF_FFF8, 32'h0000_00F8}) begin n_fail++; $display("FAIL wrap_1: addr=%h data=%h required fffffffc/fffffff8_000000f8", wbus.mem_addr, wbus.fifo_data_in); end
        cyc(0, 0, 0, 0, 0);
        n_checks++; if (wbus.mem_rd_en !== 1'b1 || wbus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_2: rd_en=%b addr=%h required 1/0", wbus.mem_rd_en, wbus.mem_addr); end
        n_checks++; if (wbus.fifo_data_in !== {32'hFFFF_FFFC, 32'h0000_00FC}) begin n_fail++; $display("FAIL wrap_wr2: data=%h required fffffffc_000000fc", wbus.fifo_data_in); end
        cyc(0, 0, 0, 0, 0);
        n_checks++; if (wbus.fifo_wr_en !== 1'b1 || wbus.fifo_data_in !== {32'h0, 32'h100}) begin n_fail++; $display("FAIL wrap_wr3: wr_en=%b data=%h required 1/00000000_00000100", wbus.fifo_wr_en, wbus.fifo_data_in); end
        wbus.fetch_en = 1'b0;
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        sb_valid         = 1'b0;
        sb_last          = '0;
        rst              = 1'b1;
        bus.fetch_en     = 1'b0;
        bus.redirect_en  = 1'b0;
        bus.redirect_pc  = '0;
        bus.fifo_full    = 1'b0;
        wbus.fetch_en    = 1'b0;
        wbus.redirect_en = 1'b0;
        wbus.redirect_pc = '0;
        wbus.fifo_full   = 1'b0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_hold();
        test_reset_hold();
        test_wrap();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction and address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port fetch_en  input  1  enables fetching when high.
REQ-006 SHALL have port redirect_en  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-007 SHALL have port redirect_pc  input  XLEN  new fetch address, word aligned.
REQ-008 SHALL have port mem_rd_en  output  1  instruction memory read request.
REQ-009 SHALL have port mem_addr  output  XLEN  read address, valid when mem_rd_en high.
REQ-010 SHALL have port mem_rd_data  input  XLEN  read data, valid exactly one cycle after mem_rd_en.
REQ-011 SHALL have port fifo_wr_en  output  1  write strobe to the downstream instruction FIFO.
REQ-012 SHALL have port fifo_data_in  output  2*XLEN  write word {pc, instr}, pc in upper half.
REQ-013 SHALL have port fifo_full  input  1  downstream FIFO full flag; no write accepted when high.

Function
REQ-014 SHALL implement states IDLE, RUN, HOLD.
REQ-015 IDLE -> RUN when fetch_en=1; RUN -> IDLE when fetch_en=0 and no response pending and hold buffer empty.
REQ-016 RUN -> HOLD when a response arrives while fifo_full=1; HOLD -> RUN when the held word is written.
REQ-017 SHALL assert mem_rd_en with mem_addr=pc in a cycle iff state RUN, fetch_en=1, fifo_full=0, hold buffer empty, redirect_en=0.
REQ-018 On each issued request SHALL latch pc into a pending-pc register, set a pending flag, and advance pc by 4 (modulo 2^XLEN, wrap 0xFFFF_FFFC -> 0x0).
REQ-019 In the cycle after a request, with fifo_full=0, SHALL assert fifo_wr_en with fifo_data_in={pending_pc, mem_rd_data}; latency request->write exactly 1 cycle.
REQ-020 In the cycle after a request, with fifo_full=1, SHALL capture {pending_pc, mem_rd_data} into a one-entry hold buffer, no write.
REQ-021 In HOLD SHALL assert fifo_wr_en with the held word in the first cycle fifo_full=0, then clear the hold buffer; no new request that cycle.
REQ-022 SHALL never assert fifo_wr_en while fifo_full=1; SHALL never drop or duplicate a fetched word absent redirect.
REQ-023 Sustained throughput SHALL be one word per cycle while fifo_full stays 0.
REQ-024 redirect_en=1 SHALL: load pc<=redirect_pc, clear pending flag (in-flight response discarded), clear hold buffer, suppress mem_rd_en and fifo_wr_en that cycle, go to RUN if fetch_en=1 else IDLE.
REQ-025 First request after redirect SHALL occur the following cycle at redirect_pc if REQ-017 conditions hold.
REQ-026 fetch_en falling SHALL stop new requests immediately; pending response and hold buffer SHALL still be delivered.
REQ-027 redirect_en simultaneous with a response or hold drain: redirect SHALL win, nothing written.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, pc=RESET_PC, pending flag 0, hold buffer empty.
REQ-029 During reset mem_rd_en=0, fifo_wr_en=0, mem_addr=RESET_PC, fifo_data_in=0.
REQ-030 Reset mid-operation SHALL discard pending and held words; no write on the cycle after release.
REQ-031 After rst release with fetch_en=1 SHALL issue the first request at RESET_PC within 2 cycles.

Verification
REQ-032 Streaming: rst release, fetch_en=1, fifo_full=0, memory returns addr+0x100 -> writes {0x0,0x100},{0x4,0x104},{0x8,0x108} on consecutive cycles.
REQ-033 Backpressure: fifo_full rises the cycle after request to 0x8 -> word held, no write; fifo_full falls 3 cycles later -> single write {0x8,0x108}, next request 0xC.
REQ-034 Redirect: redirect_en=1, redirect_pc=0x40 while response for 0xC in flight -> 0xC never written; next request 0x40, write {0x40,0x140}.
REQ-035 Wrap: RESET_PC=0xFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-036 Reset mid-HOLD: assert rst with held word -> no write ever; after release first request at RESET_PC.
REQ-037 Scoreboard on all scenarios: fifo_wr_en never high while fifo_full high; written pcs strictly sequential between redirects.
